seg7_scan_arbiter: RTL and testbench

SEG7_SCAN_ARBITER -- requirements
Module: seg7_scan_arbiter

---
 rtl/seg7_pkg.sv | 36 +++
 rtl/seg7_digit_enc.sv | 25 ++
 rtl/seg7_scan_arbiter.sv | 176 +++++++++++++++++
 tb/tb_seg7_scan_arbiter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared types and constants for the seg7 scan arbiter: the scan FSM states,
// the segment encodings and the all-off levels.
package seg7_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHOW  = 2'd1,
    ST_BLANK = 2'd2
  } state_t;

  // Segment bit order {a,b,c,d,e,f,g,dp}, active-high.
  localparam logic [7:0] SEG_0 = 8'hFC;
  localparam logic [7:0] SEG_1 = 8'h60;
  localparam logic [7:0] SEG_2 = 8'hDA;
  localparam logic [7:0] SEG_3 = 8'hF2;
  localparam logic [7:0] SEG_4 = 8'h66;
  localparam logic [7:0] SEG_5 = 8'hB6;
  localparam logic [7:0] SEG_6 = 8'hBE;
  localparam logic [7:0] SEG_7 = 8'hE0;
  localparam logic [7:0] SEG_8 = 8'hFE;
  localparam logic [7:0] SEG_9 = 8'hF6;

  localparam logic [7:0] SEG_BLANK   = 8'h00;
  localparam logic [7:0] SEL_ALL_OFF = 8'hFF;

  // Index of the most significant non-zero nibble; 0 when the word is zero.
  function automatic logic [2:0] msd_index(input logic [31:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int k = 0; k < 8; k++) begin
      if (v[k*4 +: 4] != 4'd0) idx = 3'(k);
    end
    return idx;
  endfunction

endpackage

// File: rtl/seg7_digit_enc.sv
// BCD nibble to seven-segment pattern; non-decimal nibbles render as all-off.
module seg7_digit_enc
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] seg
);

  always_comb begin
    case (nibble)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_arbiter.sv
// Two-requester arbiter for a multiplexed 8-digit seven-segment display.
// Optional leading-zero blanking is enabled by defining SEG7_LZ_BLANK_EN.
module seg7_scan_arbiter
  import seg7_pkg::*;
#(
  parameter int unsigned SCAN_DIV    = 1000,
  parameter int unsigned BLANK_CYC   = 16,
  parameter int unsigned HOLD_FRAMES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic [31:0] data0,
  input  logic        req1,
  input  logic [31:0] data1,
  output logic        grant0,
  output logic        grant1,
  output logic [7:0]  seg_data,
  output logic [7:0]  seg_sel
);

  localparam logic [31:0] SHOW_LAST  = 32'(SCAN_DIV - 1);
  localparam logic [31:0] BLANK_LAST = 32'(BLANK_CYC - 1);
  localparam logic [31:0] HOLD_MAX   = 32'(HOLD_FRAMES);

  state_t      state_q, state_d;
  logic [2:0]  digit_q, digit_d;
  logic [31:0] phase_q, phase_d;
  logic [31:0] held_q, held_d, held_inc;
  logic        grant0_q, grant0_d;
  logic        grant1_q, grant1_d;
  logic        rr_ptr_q, rr_ptr_d;
  logic [31:0] shadow_q, shadow_d;
  logic [7:0]  seg_sel_q, seg_sel_d;
  logic [7:0]  seg_data_q, seg_data_d;

  logic        owner, own_req, oth_req;
  logic        start, start_owner;
  logic [3:0]  nibble_sel;
  logic [7:0]  enc_seg;

  always_comb begin
    state_d     = state_q;
    digit_d     = digit_q;
    phase_d     = phase_q;
    held_d      = held_q;
    grant0_d    = grant0_q;
    grant1_d    = grant1_q;
    rr_ptr_d    = rr_ptr_q;
    shadow_d    = shadow_q;
    start       = 1'b0;
    start_owner = 1'b0;

    // held_inc counts the frame that is completing right now.
    held_inc = (held_q >= HOLD_MAX) ? HOLD_MAX : held_q + 32'd1;
    owner    = grant1_q;
    own_req  = owner ? req1 : req0;
    oth_req  = owner ? req0 : req1;

    case (state_q)
      ST_IDLE: begin
        if (req0 || req1) begin
          start       = 1'b1;
          start_owner = (req0 && req1) ? rr_ptr_q : req1;
          held_d      = 32'd0;
        end
      end
      ST_SHOW: begin
        if (phase_q == SHOW_LAST) begin
          state_d = ST_BLANK;
          phase_d = 32'd0;
        end else begin
          phase_d = phase_q + 32'd1;
        end
      end
      ST_BLANK: begin
        if (phase_q != BLANK_LAST) begin
          phase_d = phase_q + 32'd1;
        end else if (digit_q != 3'd7) begin
          state_d = ST_SHOW;
          digit_d = digit_q + 3'd1;
          phase_d = 32'd0;
        end else if (!own_req) begin
          if (oth_req) begin
            start       = 1'b1;
            start_owner = ~owner;
            held_d      = 32'd0;
          end else begin
            state_d  = ST_IDLE;
            digit_d  = 3'd0;
            phase_d  = 32'd0;
            grant0_d = 1'b0;
            grant1_d = 1'b0;
            held_d   = 32'd0;
          end
        end else if (oth_req && (held_inc >= HOLD_MAX)) begin
          start       = 1'b1;
          start_owner = ~owner;
          held_d      = 32'd0;
        end else begin
          start       = 1'b1;
          start_owner = owner;
          held_d      = held_inc;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Every new frame (fresh grant or kept owner) reloads the shadow copy.
    if (start) begin
      state_d  = ST_SHOW;
      digit_d  = 3'd0;
      phase_d  = 32'd0;
      grant0_d = ~start_owner;
      grant1_d = start_owner;
      rr_ptr_d = ~start_owner;
      shadow_d = start_owner ? data1 : data0;
    end
  end

  assign nibble_sel = shadow_d[{digit_d, 2'b00} +: 4];

  seg7_digit_enc u_enc (
    .nibble (nibble_sel),
    .seg    (enc_seg)
  );

  always_comb begin
    seg_sel_d  = SEL_ALL_OFF;
    seg_data_d = SEG_BLANK;
    if (state_d == ST_SHOW) begin
      seg_sel_d = ~(8'b0000_0001 << digit_d);
`ifdef SEG7_LZ_BLANK_EN
      if ((digit_d != 3'd0) && (digit_d > msd_index(shadow_d))) begin
        seg_data_d = SEG_BLANK;
      end else begin
        seg_data_d = enc_seg;
      end
`else
      seg_data_d = enc_seg;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      digit_q    <= 3'd0;
      phase_q    <= 32'd0;
      held_q     <= 32'd0;
      grant0_q   <= 1'b0;
      grant1_q   <= 1'b0;
      rr_ptr_q   <= 1'b0;
      shadow_q   <= 32'd0;
      seg_sel_q  <= SEL_ALL_OFF;
      seg_data_q <= SEG_BLANK;
    end else begin
      state_q    <= state_d;
      digit_q    <= digit_d;
      phase_q    <= phase_d;
      held_q     <= held_d;
      grant0_q   <= grant0_d;
      grant1_q   <= grant1_d;
      rr_ptr_q   <= rr_ptr_d;
      shadow_q   <= shadow_d;
      seg_sel_q  <= seg_sel_d;
      seg_data_q <= seg_data_d;
    end
  end

  assign grant0   = grant0_q;
  assign grant1   = grant1_q;
  assign seg_sel  = seg_sel_q;
  assign seg_data = seg_data_q;

endmodule

// File: tb/tb_seg7_scan_arbiter.sv
// Scoreboard bench for seg7_scan_arbiter with SCAN_DIV=4, BLANK_CYC=2, HOLD_FRAMES=2.
module tb_seg7_scan_arbiter;

  localparam int SD = 4;
  localparam int BC = 2;

  logic        clk;
  logic        rst;
  logic        req0, req1;
  logic [31:0] data0, data1;
  logic        grant0, grant1;
  logic [7:0]  seg_data, seg_sel;

  seg7_scan_arbiter #(
    .SCAN_DIV    (SD),
    .BLANK_CYC   (BC),
    .HOLD_FRAMES (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req0     (req0),
    .data0    (data0),
    .req1     (req1),
    .data1    (data1),
    .grant0   (grant0),
    .grant1   (grant1),
    .seg_data (seg_data),
    .seg_sel  (seg_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       g0;
    logic       g1;
    logic [7:0] sel;
    logic [7:0] dat;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc_no   = 0;

  function automatic logic [7:0] enc(input logic [3:0] v);
    case (v)
      4'h0: return 8'hFC;
      4'h1: return 8'h60;
      4'h2: return 8'hDA;
      4'h3: return 8'hF2;
      4'h4: return 8'h66;
      4'h5: return 8'hB6;
      4'h6: return 8'hBE;
      4'h7: return 8'hE0;
      4'h8: return 8'hFE;
      4'h9: return 8'hF6;
      default: return 8'h00;
    endcase
  endfunction

  task automatic push_run(input logic g0, input logic g1, input logic [7:0] sel,
                          input logic [7:0] dat, input int n);
    exp_t e;
    e.g0 = g0; e.g1 = g1; e.sel = sel; e.dat = dat;
    repeat (n) exp_q.push_back(e);
  endtask

  task automatic push_idle(input int n);
    push_run(1'b0, 1'b0, 8'hFF, 8'h00, n);
  endtask

  task automatic push_frame(input logic owner, input logic [31:0] d);
    int msd;
    logic [7:0] s;
    logic [7:0] sel;
    msd = 0;
    for (int k = 0; k < 8; k++) if (d[k*4 +: 4] != 4'h0) msd = k;
    for (int k = 0; k < 8; k++) begin
      s = enc(d[k*4 +: 4]);
`ifdef SEG7_LZ_BLANK_EN
      if (k > msd) s = 8'h00;
`endif
      sel = 8'h01 << k;
      sel = ~sel;
      push_run(!owner, owner, sel, s, SD);
      push_run(!owner, owner, 8'hFF, 8'h00, BC);
    end
  endtask

  // Monitor: compares the display state against the scoreboard each cycle.
  always @(negedge clk) begin
    exp_t e;
    cyc_no++;
    if (!rst && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if ({grant0, grant1, seg_sel, seg_data} !== {e.g0, e.g1, e.sel, e.dat}) begin
        n_errors++;
        $display("FAIL scan cyc=%0d got g0=%b g1=%b sel=%h dat=%h, want g0=%b g1=%b sel=%h dat=%h",
                 cyc_no, grant0, grant1, seg_sel, seg_data, e.g0, e.g1, e.sel, e.dat);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while (exp_q.size() > 0 && t < 3000) begin
      @(posedge clk);
      t++;
    end
    if (exp_q.size() > 0) begin
      n_errors++;
      $display("FAIL %s timeout pending=%0d want=0", name, exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
    $display("done %s", name);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    cyc(1);
  endtask

  initial begin
    rst = 1'b0; req0 = 1'b0; req1 = 1'b0; data0 = '0; data1 = '0;
    #1 rst = 1'b1;
    #2;
    check("rst_sel", {24'd0, seg_sel}, 32'hFF);
    check("rst_data", {24'd0, seg_data}, 32'h00);
    check("rst_grants", {30'd0, grant0, grant1}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    cyc(1);

    // Single owner, then req0 dropped in digit 3: finish frame, go IDLE.
    data0 = 32'h00000123; req0 = 1'b1;
    push_idle(1); push_frame(1'b0, 32'h00000123); push_idle(3);
    cyc(20);
    req0 = 1'b0;
    wait_drain("single_owner_drop");

    // Data change in digit 1 only shows from the next frame.
    data0 = 32'h00000123; req0 = 1'b1;
    push_idle(1); push_frame(1'b0, 32'h00000123); push_frame(1'b0, 32'h00000456); push_idle(2);
    cyc(9);
    data0 = 32'h00000456;
    cyc(50);
    req0 = 1'b0;
    wait_drain("shadow_update");

    // Both requesting from reset: alternating two-frame holds.
    reset_dut();
    data0 = 32'h00000123; data1 = 32'h00000089; req0 = 1'b1; req1 = 1'b1;
    push_idle(1);
    push_frame(1'b0, 32'h00000123); push_frame(1'b0, 32'h00000123);
    push_frame(1'b1, 32'h00000089); push_frame(1'b1, 32'h00000089);
    push_frame(1'b0, 32'h00000123); push_idle(2);
    cyc(198);
    req0 = 1'b0; req1 = 1'b0;
    wait_drain("round_robin");

    // Requester 1 alone, all digits non-zero.
    data1 = 32'h87654321; req1 = 1'b1;
    push_idle(1); push_frame(1'b1, 32'h87654321); push_idle(2);
    cyc(5);
    req1 = 1'b0;
    wait_drain("req1_only");

    // Leading zeros with a single significant digit.
    data0 = 32'h00000007; req0 = 1'b1;
    push_idle(1); push_frame(1'b0, 32'h00000007); push_idle(2);
    cyc(5);
    req0 = 1'b0;
    wait_drain("leading_zero");

    // Non-decimal nibbles render as all-off.
    data0 = 32'h0000A0B5; req0 = 1'b1;
    push_idle(1); push_frame(1'b0, 32'h0000A0B5); push_idle(2);
    cyc(5);
    req0 = 1'b0;
    wait_drain("hex_nibbles");

    // Asynchronous reset in the middle of SHOW.
    data0 = 32'h00000123; req0 = 1'b1;
    cyc(3);
    check("pre_rst_sel", {24'd0, seg_sel}, 32'hFE);
    check("pre_rst_data", {24'd0, seg_data}, 32'hF2);
    check("pre_rst_grant0", {31'd0, grant0}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_sel", {24'd0, seg_sel}, 32'hFF);
    check("async_rst_data", {24'd0, seg_data}, 32'h00);
    check("async_rst_grants", {30'd0, grant0, grant1}, 32'd0);
    req0 = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    cyc(2);
    check("post_rst_sel", {24'd0, seg_sel}, 32'hFF);
    check("post_rst_grants", {30'd0, grant0, grant1}, 32'd0);
    $display("done async_reset");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
